// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: FSM encoding and word geometry.
package mem_access_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned OFFSET_BITS = $clog2(WORD_BYTES);
    localparam logic [31:0] ALIGN_MASK  = 32'(WORD_BYTES - 1);

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding word load/store initiator between execute stage and data RAM.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_datain,
    output logic                mem_write,
    output logic                mem_read,
    input  logic [31:0]         mem_dataout,
    output logic [CNT_BITS-1:0] load_cnt,
    output logic [CNT_BITS-1:0] store_cnt,
    output logic [CNT_BITS-1:0] err_cnt
);

    localparam int unsigned RANGE_SHIFT = ADDR_BITS + OFFSET_BITS;

    state_t state;
    state_t state_nxt;
    logic   lat_write;
    logic   accept_c;
    logic   req_err_c;
    logic   load_inc_c;
    logic   store_inc_c;
    logic   err_inc_c;

    // Misaligned or beyond the RAM's byte range
    assign req_err_c = ((req_addr & ALIGN_MASK) != 32'd0) ||
                       ((req_addr >> RANGE_SHIFT) != 32'd0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        load_inc_c  = 1'b0;
        store_inc_c = 1'b0;
        err_inc_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c  = 1'b1;
                    err_inc_c = req_err_c;
                    state_nxt = req_err_c ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                load_inc_c  = ~lat_write;
                store_inc_c = lat_write;
                state_nxt   = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they occupy exactly the ACCESS cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_addr   <= 32'd0;
            mem_datain <= 32'd0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            lat_write  <= 1'b0;
        end else begin
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            if (accept_c) begin
                resp_rdata <= 32'd0;
                resp_err   <= req_err_c;
                lat_write  <= req_write;
                if (!req_err_c) begin
                    mem_addr   <= req_addr;
                    mem_datain <= req_wdata;
                    mem_write  <= req_write;
                    mem_read   <= ~req_write;
                end
            end
            if (load_inc_c) begin
                resp_rdata <= mem_dataout;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_BITS)) u_load_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (load_inc_c),
        .count (load_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_store_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (store_inc_c),
        .count (store_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_err_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (err_inc_c),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data RAM.
module tb_mem_access_unit;

    localparam int unsigned ADDR_BITS = 5;
    // Narrow counters keep the saturation run short in cycles
    localparam int unsigned CNT_BITS  = 8;
    localparam int unsigned CNT_MAX   = (1 << CNT_BITS) - 1;

    logic                Clock = 1'b0;
    logic                Reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_write = 1'b0;
    logic [31:0]         req_addr = 32'd0;
    logic [31:0]         req_wdata = 32'd0;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_datain;
    logic                mem_write;
    logic                mem_read;
    logic [31:0]         mem_dataout;
    logic [CNT_BITS-1:0] load_cnt;
    logic [CNT_BITS-1:0] store_cnt;
    logic [CNT_BITS-1:0] err_cnt;

    logic [31:0] ram [0:(1<<ADDR_BITS)-1];
    logic        preload = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    mem_access_unit #(.ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_dataout (mem_dataout),
        .load_cnt    (load_cnt),
        .store_cnt   (store_cnt),
        .err_cnt     (err_cnt)
    );

    assign mem_dataout = ram[mem_addr[ADDR_BITS+1:2]];

    always @(posedge Clock) begin
        if (preload) begin
            for (int i = 0; i < (1 << ADDR_BITS); i++) ram[i] <= 32'd0;
            ram[0] <= 32'd30;
            ram[1] <= 32'd20;
            ram[2] <= 32'd10;
            ram[3] <= 32'd40;
        end else if (mem_write) begin
            ram[mem_addr[ADDR_BITS+1:2]] <= mem_datain;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One request; lat counts edges after accept until resp_valid (1 = valid, 0 = error)
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wr, output int rd,
                          output logic [31:0] rdata, output logic err);
        @(negedge Clock);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        lat = 0; wr = 0; rd = 0;
        while (!resp_valid && lat < 10) begin
            if (mem_write) wr++;
            if (mem_read) rd++;
            @(posedge Clock); #1;
            lat++;
        end
        rdata = resp_rdata;
        err = resp_err;
        @(negedge Clock);
        resp_ready = 1'b1;
        @(posedge Clock); #1;
        resp_ready = 1'b0;
        if (mem_write) wr++;
        if (mem_read) rd++;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_load;
        int          exp_store;
        int          exp_errc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, wr, rd;
        logic [31:0] rdata;
        logic err;

        vecs[0] = '{1'b0, 32'd4,   32'd0,          32'd20,         1'b0, 1, 0, 0};
        vecs[1] = '{1'b1, 32'd12,  32'd0,          32'd0,          1'b0, 1, 1, 0};
        vecs[2] = '{1'b0, 32'd12,  32'd0,          32'd0,          1'b0, 2, 1, 0};
        vecs[3] = '{1'b0, 32'd6,   32'd0,          32'd0,          1'b1, 2, 1, 1};
        vecs[4] = '{1'b0, 32'h100, 32'd0,          32'd0,          1'b1, 2, 1, 2};
        vecs[5] = '{1'b1, 32'd124, 32'hDEADBEEF,   32'd0,          1'b0, 2, 2, 2};
        vecs[6] = '{1'b0, 32'd124, 32'd0,          32'hDEADBEEF,   1'b0, 3, 2, 2};
        vecs[7] = '{1'b0, 32'd128, 32'd0,          32'd0,          1'b1, 3, 2, 3};
        vecs[8] = '{1'b1, 32'd3,   32'd5,          32'd0,          1'b1, 3, 2, 4};

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_datain", mem_datain, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_counters", {8'd0, load_cnt, store_cnt, err_cnt}, 32'd0);
        Reset = 1'b0;
        preload = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, lat, wr, rd, rdata, err);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_write_pulses", i), 32'(wr),
                (vecs[i].w && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_read_pulses", i), 32'(rd),
                (!vecs[i].w && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_load_cnt", i), 32'(load_cnt), 32'(vecs[i].exp_load));
            chk($sformatf("v%0d_store_cnt", i), 32'(store_cnt), 32'(vecs[i].exp_store));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_errc));
        end
        chk("ram3_after_store", ram[3], 32'd0);
        chk("ram31_after_store", ram[31], 32'hDEADBEEF);

        // Back-pressure: response held while resp_ready low, new requests ignored
        @(negedge Clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0;
        @(posedge Clock); #1;
        req_addr = 32'd8;
        @(posedge Clock); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_resp_valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", c), resp_rdata, 32'd30);
            chk($sformatf("hold%0d_req_ready", c), 32'(req_ready), 32'd0);
            @(posedge Clock); #1;
        end
        chk("hold_load_cnt", 32'(load_cnt), 32'd4);
        @(negedge Clock);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge Clock); #1;
        resp_ready = 1'b0;
        chk("release_resp_valid", 32'(resp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        @(posedge Clock); #1;
        chk("release_no_new_req", 32'(load_cnt), 32'd4);

        // Reset asserted inside the ACCESS cycle of a store
        @(negedge Clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd8; req_wdata = 32'd99;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        chk("abort_write_before", 32'(mem_write), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("abort_write_dropped", 32'(mem_write), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_counters", {8'd0, load_cnt, store_cnt, err_cnt}, 32'd0);
        @(posedge Clock); #1;
        chk("abort_ram2", ram[2], 32'd10);
        chk("abort_store_cnt", 32'(store_cnt), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // Saturation of the load counter
        for (int n = 0; n < int'(CNT_MAX) + 5; n++) begin
            do_req(1'b0, 32'd4, 32'd0, lat, wr, rd, rdata, err);
            if (n == int'(CNT_MAX) - 2) chk("sat_below_max", 32'(load_cnt), 32'(CNT_MAX - 1));
        end
        chk("sat_load_cnt", 32'(load_cnt), 32'(CNT_MAX));
        chk("sat_last_rdata", rdata, 32'd20);
        chk("sat_store_cnt", 32'(store_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the single-cycle MIPS computer. Sits between the execute stage and the data RAM, accepts one word load or store request at a time over a valid/ready handshake, and drives the RAM's address, write-data, `write` and `read` strobes. Returns load data or a completion acknowledgement with an error flag. Keeps saturating load, store and error counters for debug.

## Interface
Parameters:
- `ADDR_BITS`, 5, word-index width; RAM holds 2^ADDR_BITS words, byte address range 0 .. 4·2^ADDR_BITS−1.
- `CNT_BITS`, 16, width of each statistics counter.

Ports (one clock; reset is asynchronous and active-high):
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store (sw), 0 = load (lw).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.
- `mem_addr`  out  32  to RAM `addr`.
- `mem_datain`  out  32  to RAM `datain`.
- `mem_write`  out  1  to RAM `write`.
- `mem_read`  out  1  to RAM `read`.
- `mem_dataout`  in  32  from RAM `dataout` (combinational read).
- `load_cnt`, `store_cnt`, `err_cnt`  out  CNT_BITS  saturating counters.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch write/addr/wdata. Error if `req_addr[1:0]`≠0 or `req_addr[31:ADDR_BITS+2]`≠0. Error → RESP with `resp_err`=1, `err_cnt`+1, no RAM strobe. Otherwise → ACCESS.
- ACCESS (exactly one cycle): `mem_addr` = latched address.
  - Store: `mem_write`=1, `mem_datain` = latched data; RAM writes on the closing edge; `store_cnt`+1.
  - Load: `mem_read`=1; `mem_dataout` is captured into `resp_rdata` on the closing edge; `load_cnt`+1.
  - Always → RESP.
- RESP: `resp_valid`=1. Response outputs are held stable until `resp_ready`. On `resp_ready` → IDLE.
- Outside ACCESS: `mem_write`=0, `mem_read`=0. `mem_addr` and `mem_datain` hold their last values; they are don't-care while no strobe is asserted.
- Counters: +1 per event, saturate at all-ones, never wrap.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_*` outputs 0, all counters 0.
- Reset is asynchronous. Asserting it mid-ACCESS drops `mem_write` immediately, so no RAM write completes on the following edge. Asserting it mid-RESP discards the pending response.
- Latency, valid request: accept edge N, ACCESS during cycle N+1, `resp_valid` high from cycle N+2. Error request: `resp_valid` high from cycle N+1.
- Response in the same cycle as `resp_ready`: the unit is in IDLE on the next cycle. Back-to-back throughput is one request per 3 cycles (2 for errors).
- `req_ready` is low in ACCESS and RESP. `req_valid` asserted there is ignored and does not need to be held stable by the unit.
- `resp_ready` outside RESP is ignored.

## Structure
- Shared package `mem_access_pkg`:
  - state enum (IDLE, ACCESS, RESP);
  - `WORD_BYTES`=4;
  - alignment-mask constant.
- One sub-module: `sat_counter` (width parameter; `inc` and async `Reset` inputs), instantiated three times.
- The FSM, request latch and error check stay in the top module.

## Test plan
- Bench setup: data RAM model preloaded with ram[0..3] = 30, 20, 10, 40.
- Load `req_addr`=4 → `resp_valid` two cycles after accept, `resp_rdata`=20, `resp_err`=0, `load_cnt`=1.
- Store 0 to `req_addr`=12, then load 12 → first response `resp_rdata`=0, `store_cnt`=1; second response `resp_rdata`=0 (was 40); `mem_write` high for exactly one cycle.
- Load `req_addr`=6 (misaligned) and load `req_addr`=0x100 (out of range) → each gives `resp_err`=1 after one cycle, with no `mem_read`/`mem_write` pulse; `err_cnt`=2.
- Hold `resp_ready`=0 for 5 cycles after a load of address 0 → `resp_valid` and `resp_rdata`=30 stay stable and `req_ready`=0 throughout; release → IDLE next cycle.
- Assert `Reset` during the ACCESS cycle of a store of 99 to address 8 → `mem_write` falls immediately, ram[2] stays 10, outputs return to reset values.
- Drive 65 540 load requests with `CNT_BITS`=16 → `load_cnt` saturates at 65 535.
